// File: rtl/boot_loader.sv
// boot_loader: fills instruction memory from a little-endian byte stream
// (32-bit word count N, then N words) and holds the core in reset until a
// complete, valid image has been written.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> a 4-byte checksum (mod-2**32 sum of the N words) follows the
//                image; a mismatch aborts the load into ERROR.
//   undefined -> no checksum state and no adder; DONE follows the last word.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start_i           begin/restart a load (level, sampled every cycle)
//   byte_valid_i      byte_data_i carries a byte
//   byte_data_i[7:0]  stream byte
//   byte_ready_o      loader accepts a byte this cycle (LEN/DATA/CSUM)
//   imem_we_o         one-cycle write strobe per assembled word
//   imem_waddr_o      word address of the write
//   imem_wdata_o      word to write
//   core_rst_o        core reset, low only in DONE
//   busy_o            load in progress
//   done_o            load completed successfully
//   err_o             load aborted (oversize or checksum mismatch)
module boot_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_waddr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  core_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERROR} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shreg_q;
    logic [31:0]       n_q;
    logic [31:0]       word_cnt_q;
    logic [CNT_W-1:0]  addr_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       csum_q;
`endif

    logic              accept_c;
    logic              word_done_c;
    logic [31:0]       word_c;
    logic              last_word_c;
    logic              clear_c;
    logic              len_done_c;
    logic              data_word_c;
    logic              write_c;

    // A byte arriving together with start_i is dropped.
    assign accept_c    = byte_valid_i && byte_ready_o && !start_i;
    assign word_done_c = accept_c && (byte_cnt_q == 2'd3);
    // Bytes shift in from the top so the 4th byte completes the LSB-first word.
    assign word_c      = {byte_data_i, shreg_q};
    assign last_word_c = ((word_cnt_q + 32'd1) == n_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_d     = state_q;
        clear_c     = 1'b0;
        len_done_c  = 1'b0;
        data_word_c = 1'b0;
        write_c     = 1'b0;
        if (start_i) begin
            state_d = S_LEN;
            clear_c = 1'b1;
        end else begin
            case (state_q)
                S_LEN: begin
                    if (word_done_c) begin
                        len_done_c = 1'b1;
                        if (word_c == 32'd0) begin
                            state_d = S_TAIL;
                        end else if ({1'b0, word_c} > CAPACITY) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_done_c) begin
                        data_word_c = 1'b1;
                        // Address MSB can only be set past capacity; never write there.
                        write_c     = !addr_q[ADDR_WIDTH];
                        if (last_word_c) begin
                            state_d = S_TAIL;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (word_done_c) begin
                        state_d = (word_c == csum_q) ? S_DONE : S_ERROR;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Byte assembly, counters, memory write port and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q   <= 2'd0;
            shreg_q      <= 24'd0;
            n_q          <= 32'd0;
            word_cnt_q   <= 32'd0;
            addr_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 32'd0;
`endif
            byte_ready_o <= 1'b0;
            imem_we_o    <= 1'b0;
            imem_waddr_o <= '0;
            imem_wdata_o <= 32'd0;
            core_rst_o   <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            imem_we_o <= write_c;
            if (write_c) begin
                imem_waddr_o <= addr_q[ADDR_WIDTH-1:0];
                imem_wdata_o <= word_c;
            end

            if (clear_c) begin
                byte_cnt_q <= 2'd0;
                n_q        <= 32'd0;
                word_cnt_q <= 32'd0;
                addr_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= 32'd0;
`endif
            end else if (accept_c) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shreg_q    <= word_c[31:8];
                if (len_done_c) begin
                    n_q <= word_c;
                end
                if (data_word_c) begin
                    word_cnt_q <= word_cnt_q + 32'd1;
                    addr_q     <= addr_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_q     <= csum_q + word_c;
`endif
                end
            end

            byte_ready_o <= (state_d == S_LEN) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                            || (state_d == S_CSUM)
`endif
                            ;
            busy_o       <= (state_d == S_LEN) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                            || (state_d == S_CSUM)
`endif
                            ;
            done_o       <= (state_d == S_DONE);
            err_o        <= (state_d == S_ERROR);
            core_rst_o   <= (state_d != S_DONE);
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader (ADDR_WIDTH=2, capacity 4 words).
// Images are built from random words; expected writes and final status come
// from a queue-based image model. Honours LOADER_CHECKSUM_EN like the design.
module tb_boot_loader;

    localparam int unsigned AW  = 2;
    localparam int unsigned CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_waddr_o;
    logic [31:0]   imem_wdata_o;
    logic          core_rst_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];

    boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o),
        .imem_waddr_o(imem_waddr_o), .imem_wdata_o(imem_wdata_o),
        .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle and score any memory write against the image model.
    task automatic step_cycle();
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        @(posedge clk);
        #1;
        if (imem_we_o === 1'b1) begin
            tests_run++;
            if (exp_data_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, expected no write", imem_waddr_o, imem_wdata_o);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (imem_waddr_o !== ea || imem_wdata_o !== ed) begin
                    tests_failed++;
                    $display("FAIL write: got addr=%0d data=%08h, expected addr=%0d data=%08h", imem_waddr_o, imem_wdata_o, ea, ed);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  guard;
        logic rdy;
        byte_data_i = b;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                byte_valid_i = 1'b0;
                step_cycle();
            end
        end
        byte_valid_i = 1'b1;
        guard = 0;
        while (1) begin
            rdy = byte_ready_o;
            step_cycle();
            if (rdy === 1'b1) break;
            guard++;
            if (guard > 20) begin
                tests_run++;
                tests_failed++;
                $display("FAIL byte_timeout: byte_ready_o=%b, expected 1 within 20 cycles", byte_ready_o);
                break;
            end
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    // start_i pulse with a junk byte alongside it, which must be discarded.
    task automatic do_start();
        start_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_data_i  = 8'($urandom);
        step_cycle();
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] image_sum(input logic [31:0] words[$]);
        logic [31:0] s = 32'd0;
        foreach (words[i]) s += words[i];
        return s;
    endfunction

    // Reference outcome of a whole image.
    function automatic bit image_bad(input logic [31:0] n, input logic [31:0] words[$], input logic [31:0] csum);
        if (n > CAP) return 1'b1;
`ifdef LOADER_CHECKSUM_EN
        return image_sum(words) != csum;
`else
        return (csum != csum);
`endif
    endfunction

    // Sends header, words and (if enabled) checksum; queues expected writes.
    task automatic run_image(input logic [31:0] n, input logic [31:0] words[$], input logic [31:0] csum, input bit gaps);
        send_word(n, gaps);
        if (n <= CAP) begin
            foreach (words[k]) begin
                exp_addr_q.push_back(AW'(k));
                exp_data_q.push_back(words[k]);
            end
            foreach (words[k]) send_word(words[k], gaps);
`ifdef LOADER_CHECKSUM_EN
            send_word(csum, gaps);
`endif
        end
    endtask

    task automatic wait_outcome(input string name, input bit exp_err);
        int   guard = 0;
        logic exp_done;
        exp_done = ~exp_err;
        while (!(done_o === 1'b1 || err_o === 1'b1) && guard < 20) begin
            step_cycle();
            guard++;
        end
        tests_run++;
        if (done_o !== exp_done || err_o !== exp_err || core_rst_o !== exp_err || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_status: got done=%b err=%b core_rst=%b busy=%b, expected done=%b err=%b core_rst=%b busy=0",
                     name, done_o, err_o, core_rst_o, busy_o, exp_done, exp_err, exp_err);
        end
        tests_run++;
        if (exp_data_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_writes: got %0d writes still outstanding, expected 0", name, exp_data_q.size());
            exp_addr_q.delete();
            exp_data_q.delete();
        end
    endtask

    task automatic check_reset_values(input string name);
        tests_run++;
        if (byte_ready_o !== 1'b0 || imem_we_o !== 1'b0 || imem_waddr_o !== '0 || imem_wdata_o !== 32'd0 ||
            core_rst_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got rdy=%b we=%b addr=%0d data=%08h core_rst=%b busy=%b done=%b err=%b, expected 0 0 0 0 1 0 0 0",
                     name, byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o, core_rst_o, busy_o, done_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step_cycle();
        step_cycle();
        check_reset_values("reset");
        rst = 1'b0;
        step_cycle();
        step_cycle();
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_load_n2();
        logic [31:0] w[$];
        w = {32'h0000_0013, 32'h0010_0093};
        do_start();
        tests_run++;
        if (busy_o !== 1'b1 || byte_ready_o !== 1'b1 || core_rst_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_busy: got busy=%b rdy=%b core_rst=%b, expected 1 1 1", busy_o, byte_ready_o, core_rst_o);
        end
        send_word(32'd2, 1'b0);
        exp_addr_q.push_back(AW'(0));
        exp_data_q.push_back(w[0]);
        send_word(w[0], 1'b0);
        tests_run++;
        if (imem_we_o !== 1'b1 || exp_data_q.size() != 0) begin
            tests_failed++;
            $display("FAIL write_latency: got we=%b pending=%0d one cycle after 4th byte, expected we=1 pending=0", imem_we_o, exp_data_q.size());
        end
        exp_addr_q.push_back(AW'(1));
        exp_data_q.push_back(w[1]);
        send_word(w[1], 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0010_00A6, 1'b0);
`endif
        wait_outcome("load_n2", 1'b0);
    endtask

    task automatic test_empty();
        logic [31:0] w[$];
        do_start();
        tests_run++;
        if (done_o !== 1'b0 || core_rst_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_from_done: got done=%b core_rst=%b, expected 0 1", done_o, core_rst_o);
        end
        run_image(32'd0, w, 32'd0, 1'b0);
        wait_outcome("empty", image_bad(32'd0, w, 32'd0));
    endtask

    task automatic test_oversize();
        logic [31:0] w[$];
        do_start();
        run_image(32'd5, w, 32'd0, 1'b0);
        wait_outcome("oversize", 1'b1);
        for (int i = 0; i < CAP; i++) w.push_back($urandom);
        do_start();
        tests_run++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_from_error: got err=%b busy=%b, expected 0 1", err_o, busy_o);
        end
        run_image(32'(CAP), w, image_sum(w), 1'b0);
        wait_outcome("full_capacity", 1'b0);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] w[$];
        w = {32'h0000_0013, 32'h0010_0093};
        do_start();
        run_image(32'd2, w, 32'h0010_00A6, 1'b1);
        wait_outcome("csum_good", image_bad(32'd2, w, 32'h0010_00A6));
        do_start();
        run_image(32'd2, w, 32'h0010_00A7, 1'b1);
        wait_outcome("csum_bad", image_bad(32'd2, w, 32'h0010_00A7));
    endtask
`endif

    task automatic test_abort_start();
        logic [31:0] w[$];
        do_start();
        send_word(32'd2, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        do_start();
        tests_run++;
        if (busy_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 || core_rst_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_start: got busy=%b done=%b err=%b core_rst=%b, expected 1 0 0 1", busy_o, done_o, err_o, core_rst_o);
        end
        w = {32'hDEAD_BEEF};
        run_image(32'd1, w, 32'hDEAD_BEEF, 1'b0);
        wait_outcome("after_abort_start", 1'b0);
    endtask

    task automatic test_abort_rst();
        logic [31:0] w[$];
        do_start();
        send_word(32'd2, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        check_reset_values("abort_rst");
        for (int i = 0; i < 6; i++) begin
            byte_valid_i = 1'($urandom);
            byte_data_i  = 8'($urandom);
            step_cycle();
        end
        byte_valid_i = 1'b0;
        check_reset_values("idle_after_abort_rst");
        w = {32'hDEAD_BEEF};
        do_start();
        run_image(32'd1, w, 32'hDEAD_BEEF, 1'b0);
        wait_outcome("after_abort_rst", 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] n;
        logic [31:0] cs;
        for (int it = 0; it < 12; it++) begin
            w.delete();
            n = 32'($urandom_range(0, CAP + 1));
            if (n <= CAP) for (int k = 0; k < int'(n); k++) w.push_back($urandom);
            cs = image_sum(w);
            if ($urandom_range(0, 2) == 0) cs = cs + 32'd1;
            do_start();
            run_image(n, w, cs, 1'b1);
            wait_outcome("random", image_bad(n, w, cs));
        end
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'd0;
        test_reset();
        test_load_n2();
        test_empty();
        test_oversize();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_abort_start();
        test_abort_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
